equalizer_v1_0: RTL and testbench

EQUALIZER_V1_0 -- requirements
Module: equalizer_v1_0

---
 rtl/equalizer_pkg.sv | 32 +++
 rtl/eq_cmult.sv | 36 +++
 rtl/equalizer_v1_0.sv | 136 +++++++++++++
 tb/tb_equalizer_v1_0.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/equalizer_pkg.sv
// Shared types and constants for the complex-gain equalizer.
// Sample packing everywhere: [15:0] I, [31:16] Q, signed Q1.15.
package equalizer_pkg;

    localparam int SAMPLE_W          = 16;
    localparam int COEF_FRAC         = 14;
    localparam int DEFAULT_FRAME_LEN = 8;
    localparam int ACC_W             = 2 * SAMPLE_W + 1;

    localparam logic signed [ACC_W-1:0] SAMPLE_MAX = ACC_W'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAMPLE_MIN = ACC_W'(-(1 << (SAMPLE_W - 1)));

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] q;
        logic signed [SAMPLE_W-1:0] i;
    } cplx_t;

    typedef enum logic {
        LOAD,
        RUN
    } eq_state_e;

    function automatic logic [SAMPLE_W-1:0] sat_sample(input logic signed [ACC_W-1:0] v);
        if (v > SAMPLE_MAX) begin
            return SAMPLE_MAX[SAMPLE_W-1:0];
        end else if (v < SAMPLE_MIN) begin
            return SAMPLE_MIN[SAMPLE_W-1:0];
        end
        return v[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/eq_cmult.sv
// Combinational complex multiply y = x*w with round-half-up and Q2.14 rescale.
// EQUALIZER_SAT_EN selects saturation of each component; otherwise it wraps.
module eq_cmult
    import equalizer_pkg::*;
(
    input  cplx_t x,
    input  cplx_t w,
    output cplx_t y
);

    localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(1 << (COEF_FRAC - 1));

    logic signed [2*SAMPLE_W-1:0] p_ii, p_qq, p_iq, p_qi;
    logic signed [ACC_W-1:0]      acc_i, acc_q, sh_i, sh_q;

    always_comb begin
        p_ii  = $signed(x.i) * $signed(w.i);
        p_qq  = $signed(x.q) * $signed(w.q);
        p_iq  = $signed(x.i) * $signed(w.q);
        p_qi  = $signed(x.q) * $signed(w.i);
        // 33-bit sums cannot overflow even for (-1)*(-1) on both terms
        acc_i = ACC_W'(p_ii) - ACC_W'(p_qq) + ROUND;
        acc_q = ACC_W'(p_iq) + ACC_W'(p_qi) + ROUND;
        sh_i  = acc_i >>> COEF_FRAC;
        sh_q  = acc_q >>> COEF_FRAC;
    end

`ifdef EQUALIZER_SAT_EN
    assign y = cplx_t'({sat_sample(sh_q), sat_sample(sh_i)});
`else
    logic unused_high;
    assign unused_high = ^{sh_i[ACC_W-1:SAMPLE_W], sh_q[ACC_W-1:SAMPLE_W]};
    assign y = cplx_t'({sh_q[SAMPLE_W-1:0], sh_i[SAMPLE_W-1:0]});
`endif

endmodule

// File: rtl/equalizer_v1_0.sv
// Per-bin complex equalizer: first frame after reset loads coefficients, then every
// sample k is multiplied by w[k]. Optional saturation via EQUALIZER_SAT_EN.
module equalizer_v1_0
    import equalizer_pkg::*;
#(
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN
) (
    input  logic        m00_axis_aclk,
    input  logic        m00_axis_aresetn,
    output logic        m00_axis_tvalid,
    output logic [31:0] m00_axis_tdata,
    output logic [3:0]  m00_axis_tstrb,
    output logic        m00_axis_tlast,
    input  logic        m00_axis_tready,
    input  logic        s00_axis_aclk,
    input  logic        s00_axis_aresetn,
    output logic        s00_axis_tready,
    input  logic [31:0] s00_axis_tdata,
    input  logic [3:0]  s00_axis_tstrb,
    input  logic        s00_axis_tlast,
    input  logic        s00_axis_tvalid
);

    localparam int               IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic clk;
    logic rst_n;
    assign clk   = m00_axis_aclk;
    assign rst_n = m00_axis_aresetn;

    // Slave-side clock/reset, strobes and tlast carry no information here.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, s00_axis_aclk, s00_axis_aresetn, s00_axis_tstrb, s00_axis_tlast};

    eq_state_e        state, state_next;
    logic [IDX_W-1:0] k;
    logic             in_ready, load_mode, run_mode;
    logic             advance, accept, last_word, load_write, run_accept;

    cplx_t            coef_mem [FRAME_LEN];
    cplx_t            s1_x, s1_w, prod;
    logic             s1_valid, s1_last;
    cplx_t            out_data;
    logic             out_valid, out_last;

    // Handshake: a word moves on any edge where valid and ready are both high.
    // The whole pipeline advances together when the output slot is empty or
    // being taken; in RUN the input ready is exactly that advance condition.
    assign advance    = m00_axis_tready | ~out_valid;
    assign accept     = s00_axis_tvalid & in_ready;
    assign last_word  = (k == LAST_IDX);
    assign load_write = accept & load_mode;
    assign run_accept = accept & run_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == LOAD && accept && last_word) begin
            state_next = RUN;
        end
    end

    always_comb begin
        in_ready  = 1'b1;
        load_mode = 1'b0;
        run_mode  = 1'b0;
        case (state)
            LOAD: load_mode = 1'b1;
            RUN: begin
                in_ready = advance;
                run_mode = 1'b1;
            end
            default: in_ready = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= '0;
        end else if (accept) begin
            k <= last_word ? '0 : k + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (load_write) begin
            coef_mem[k] <= cplx_t'(s00_axis_tdata);
        end
    end

    // Stage 1 holds operands, stage 2 is the output register fed by the multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_x      <= '0;
            s1_w      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            s1_valid  <= run_accept;
            if (run_accept) begin
                s1_x    <= cplx_t'(s00_axis_tdata);
                s1_w    <= coef_mem[k];
                s1_last <= last_word;
            end
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= prod;
                out_last <= s1_last;
            end
        end
    end

    eq_cmult u_cmult (
        .x (s1_x),
        .w (s1_w),
        .y (prod)
    );

    assign m00_axis_tvalid = out_valid;
    assign m00_axis_tdata  = out_data;
    assign m00_axis_tlast  = out_last;
    assign m00_axis_tstrb  = 4'hF;
    assign s00_axis_tready = in_ready;

endmodule

// File: tb/tb_equalizer_v1_0.sv
// Directed bench for equalizer_v1_0: unity gain, framing, rotation, rounding,
// overflow, backpressure and mid-frame reset, checked against hand-computed words.
module tb_equalizer_v1_0;

    localparam int FRAME_LEN = 8;

`ifdef EQUALIZER_SAT_EN
    localparam logic [31:0] OVF_EXP = 32'h00007FFF;
`else
    localparam logic [31:0] OVF_EXP = 32'h0000DFFE;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_tvalid, m_tlast, m_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        s_tready, s_tvalid, s_tlast;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cycle_cnt = 0;
    bit          check_lat;

    logic [31:0] exp_q[$];
    logic        exp_last_q[$];
    int          acc_q[$];

    logic [31:0] mon_exp;
    logic        mon_last;
    int          mon_acc;

    logic [31:0] unity_coef [8] = '{default: 32'h00004000};
    logic [31:0] unity_in   [8] = '{32'h00003000, 32'h0000B000, 32'h00002000, 32'h00008000,
                                    32'h00003000, 32'h0000B000, 32'h00002000, 32'h00008000};
    logic [31:0] mix_coef   [8] = '{32'h40000000, 32'h00007FFF, 32'hC0000000, 32'h20002000,
                                    32'h00002000, 32'h00002000, 32'h00004000, 32'h00004000};
    logic [31:0] mix_in     [8] = '{32'h00003000, 32'h00007000, 32'h00001000, 32'h10001000,
                                    32'h00000003, 32'h0000FFFD, 32'h7FFF8001, 32'h12345678};
    logic [31:0] mix_exp    [8] = '{32'h30000000, OVF_EXP,      32'hF0000000, 32'h10000000,
                                    32'h00000002, 32'h0000FFFF, 32'h7FFF8001, 32'h12345678};
    logic [31:0] half_coef  [8] = '{default: 32'h00002000};
    logic [31:0] half_in    [8] = '{32'h00004000, 32'h40000000, 32'h00000003, 32'h0000FFFD,
                                    32'h00008000, 32'h7FFF7FFF, 32'h00000001, 32'h00000000};
    logic [31:0] half_exp   [8] = '{32'h00002000, 32'h20000000, 32'h00000002, 32'h0000FFFF,
                                    32'h0000C000, 32'h40004000, 32'h00000001, 32'h00000000};

    equalizer_v1_0 #(.FRAME_LEN(FRAME_LEN)) dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (rst_n),
        .m00_axis_tvalid  (m_tvalid),
        .m00_axis_tdata   (m_tdata),
        .m00_axis_tstrb   (m_tstrb),
        .m00_axis_tlast   (m_tlast),
        .m00_axis_tready  (m_tready),
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis_tready  (s_tready),
        .s00_axis_tdata   (s_tdata),
        .s00_axis_tstrb   (s_tstrb),
        .s00_axis_tlast   (s_tlast),
        .s00_axis_tvalid  (s_tvalid)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every output transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(m_tvalid), 32'd0);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_last = exp_last_q.pop_front();
                mon_acc  = acc_q.pop_front();
                check("out_data", m_tdata, mon_exp);
                check("out_last", 32'(m_tlast), 32'(mon_last));
                if (check_lat) check("latency", 32'(cycle_cnt - mon_acc), 32'd2);
            end
        end
    end

    task automatic apply_reset();
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        exp_q.delete();
        exp_last_q.delete();
        acc_q.delete();
        repeat (2) @(negedge clk);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata", m_tdata, 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Offers one word; samples register their expectation at the accepting edge.
    task automatic send_word(input logic [31:0] word, input bit is_sample,
                             input logic [31:0] exp, input bit last, output int stalls);
        bit done;
        done     = 1'b0;
        stalls   = 0;
        s_tvalid = 1'b1;
        s_tdata  = word;
        while (!done && stalls < 64) begin
            @(negedge clk);
            if (s_tready) begin
                done = 1'b1;
                if (is_sample) begin
                    exp_q.push_back(exp);
                    exp_last_q.push_back(last);
                    acc_q.push_back(cycle_cnt);
                end
            end else begin
                stalls++;
            end
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 s_tvalid = 1'b0;
    endtask

    task automatic load_coefs(input logic [31:0] tab [8]);
        int stalls;
        for (int i = 0; i < FRAME_LEN; i++) begin
            send_word(tab[i], 1'b0, 32'd0, 1'b0, stalls);
            check("load_ready", 32'(stalls), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("load_quiet", 32'(m_tvalid), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_samples(input logic [31:0] xin [8], input logic [31:0] xexp [8],
                                input int n, input bit full_rate, input bit gaps);
        int stalls;
        for (int i = 0; i < n; i++) begin
            send_word(xin[i], 1'b1, xexp[i], i == FRAME_LEN - 1, stalls);
            if (full_rate) check("full_rate", 32'(stalls), 32'd0);
            if (gaps) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        s_tvalid  = 1'b0;
        s_tdata   = 32'd0;
        s_tstrb   = 4'bxxxx;
        s_tlast   = 1'bx;
        m_tready  = 1'b1;
        check_lat = 1'b1;
        #1;

        // Reset state, unity-gain load, two frames (back-to-back, then with gaps)
        apply_reset();
        check("tstrb", 32'(m_tstrb), 32'h0000000F);
        load_coefs(unity_coef);
        send_samples(unity_in, unity_in, FRAME_LEN, 1'b1, 1'b0);
        send_samples(unity_in, unity_in, FRAME_LEN, 1'b0, 1'b1);
        wait_drain();

        // Rotation, -j, mixed coefficient, rounding and overflow
        apply_reset();
        load_coefs(mix_coef);
        send_samples(mix_in, mix_exp, FRAME_LEN, 1'b1, 1'b0);
        wait_drain();

        // Three cycles of downstream backpressure in the middle of a frame
        check_lat = 1'b0;
        fork
            send_samples(mix_in, mix_exp, FRAME_LEN, 1'b0, 1'b0);
            begin
                repeat (4) @(posedge clk);
                #1 m_tready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_s_tready", 32'(s_tready), 32'd0);
                    check("stall_tvalid", 32'(m_tvalid), 32'd1);
                    check("stall_hold_data", m_tdata, exp_q[0]);
                    check("stall_hold_last", 32'(m_tlast), 32'(exp_last_q[0]));
                end
                @(posedge clk);
                #1 m_tready = 1'b1;
            end
        join
        wait_drain();
        check_lat = 1'b1;

        // Reset right after RUN sample 5 is accepted: in-flight words vanish,
        // and a fresh coefficient frame is required
        send_samples(mix_in, mix_exp, 5, 1'b1, 1'b0);
        apply_reset();
        load_coefs(half_coef);
        send_samples(half_in, half_exp, FRAME_LEN, 1'b1, 1'b0);
        wait_drain();

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
